// File: rtl/lif_spike_encoder.sv
// Leaky integrate-and-fire spike encoder: turns eight per-timestep sums into one spike train per neuron.
// Optional build macro LIF_SOFT_RESET_EN: subtract THRESHOLD on a spike instead of clearing the membrane.
module lif_spike_encoder #(
  parameter int TIMESTEPS            = 8,
  parameter int CORRECTION_ACC_WIDTH = 10,
  parameter int MEM_WIDTH            = 12,
  parameter int THRESHOLD            = 64,
  parameter int LEAK_SHIFT           = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_0,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_1,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_2,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_3,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_4,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_5,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_6,
  input  logic [CORRECTION_ACC_WIDTH-1:0] result_7,
  input  logic                            result_valid,
  output logic [TIMESTEPS-1:0]            spike_out,
  output logic                            spike_valid,
  input  logic                            spike_ready,
  output logic [15:0]                     neuron_count,
  output logic                            busy,
  output logic                            overflow_err
);

  localparam int TW = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam logic [TW-1:0]        T_LAST  = TW'(TIMESTEPS - 1);
  localparam logic [MEM_WIDTH-1:0] THRESH  = MEM_WIDTH'(THRESHOLD);
  localparam logic [MEM_WIDTH-1:0] MEM_MAX = '1;

  typedef enum logic [1:0] {IDLE, INTEGRATE, EMIT} state_t;

  state_t                          state;
  logic                            pend_full;
  logic [MEM_WIDTH-1:0]            membrane;
  logic [TW-1:0]                   t;
  logic [TIMESTEPS-1:0]            spike_acc;
  logic [CORRECTION_ACC_WIDTH-1:0] result_in [TIMESTEPS];
  logic [CORRECTION_ACC_WIDTH-1:0] pend_bank [TIMESTEPS];
  logic [CORRECTION_ACC_WIDTH-1:0] work_bank [TIMESTEPS];

  assign result_in[0] = result_0;
  assign result_in[1] = result_1;
  assign result_in[2] = result_2;
  assign result_in[3] = result_3;
  assign result_in[4] = result_4;
  assign result_in[5] = result_5;
  assign result_in[6] = result_6;
  assign result_in[7] = result_7;

  // The pending bank frees up in the same cycle IDLE hands it to the working bank.
  logic drain, accept;
  assign drain  = (state == IDLE) && pend_full;
  assign accept = result_valid && (!pend_full || drain);
  assign busy   = (state != IDLE) || pend_full;

  logic [MEM_WIDTH-1:0] leak;
  logic [MEM_WIDTH:0]   sum;
  logic [MEM_WIDTH-1:0] v_next;
  logic [MEM_WIDTH-1:0] v_after;
  logic                 fire;
  logic [TIMESTEPS-1:0] spike_next;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    leak       = (LEAK_SHIFT == 0) ? '0 : (membrane >> LEAK_SHIFT);
    sum        = {1'b0, membrane} - {1'b0, leak} + (MEM_WIDTH+1)'(work_bank[t]);
    v_next     = sum[MEM_WIDTH] ? MEM_MAX : sum[MEM_WIDTH-1:0];
    fire       = (v_next >= THRESH);
    spike_next = spike_acc;
    spike_next[t] = fire;
`ifdef LIF_SOFT_RESET_EN
    v_after    = fire ? (v_next - THRESH) : v_next;
`else
    v_after    = fire ? '0 : v_next;
`endif
  end

  // NOTE: the data banks carry no reset; pend_full and the FSM state guard every read of them.
  // NOTE: non-blocking assignment lets work_bank take the old pend_bank while pend_bank loads a new set.
  always_ff @(posedge clk) begin
    if (accept) pend_bank <= result_in;
    if (drain)  work_bank <= pend_bank;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_full    <= 1'b0;
      membrane     <= '0;
      t            <= '0;
      spike_acc    <= '0;
      spike_out    <= '0;
      spike_valid  <= 1'b0;
      neuron_count <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (result_valid && !accept) overflow_err <= 1'b1;

      if (accept)     pend_full <= 1'b1;
      else if (drain) pend_full <= 1'b0;

      case (state)
        IDLE: begin
          if (pend_full) begin
            membrane  <= '0;
            t         <= '0;
            spike_acc <= '0;
            state     <= INTEGRATE;
          end
        end
        INTEGRATE: begin
          membrane  <= v_after;
          spike_acc <= spike_next;
          t         <= t + 1'b1;
          if (t == T_LAST) begin
            spike_out   <= spike_next;
            spike_valid <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (spike_ready) begin
            spike_valid  <= 1'b0;
            neuron_count <= neuron_count + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_spike_encoder.sv
// Directed bench for lif_spike_encoder; a second instance with THRESHOLD=4095 covers membrane saturation.
module tb_lif_spike_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] res [8];
  logic       result_valid = 1'b0;
  logic       spike_ready = 1'b1;

  logic [7:0]  a_spike_out, b_spike_out;
  logic        a_spike_valid, b_spike_valid;
  logic [15:0] a_neuron_count, b_neuron_count;
  logic        a_busy, b_busy;
  logic        a_overflow_err, b_overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_spike_encoder dut_a (
    .clk(clk), .rst_n(rst_n),
    .result_0(res[0]), .result_1(res[1]), .result_2(res[2]), .result_3(res[3]),
    .result_4(res[4]), .result_5(res[5]), .result_6(res[6]), .result_7(res[7]),
    .result_valid(result_valid),
    .spike_out(a_spike_out), .spike_valid(a_spike_valid), .spike_ready(spike_ready),
    .neuron_count(a_neuron_count), .busy(a_busy), .overflow_err(a_overflow_err)
  );

  lif_spike_encoder #(.THRESHOLD(4095)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .result_0(res[0]), .result_1(res[1]), .result_2(res[2]), .result_3(res[3]),
    .result_4(res[4]), .result_5(res[5]), .result_6(res[6]), .result_7(res[7]),
    .result_valid(result_valid),
    .spike_out(b_spike_out), .spike_valid(b_spike_valid), .spike_ready(spike_ready),
    .neuron_count(b_neuron_count), .busy(b_busy), .overflow_err(b_overflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one result_valid pulse starting at a negedge; returns one cycle later.
  task automatic send(input logic [9:0] v);
    @(negedge clk);
    for (int i = 0; i < 8; i++) res[i] = v;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  // Counts cycles from the pulse until spike_valid rises, bounded at 40.
  task automatic wait_spike(output int lat);
    lat = 1;
    while (!a_spike_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int lat;
  int hs;
  logic [7:0] hs_exp [2];

  initial begin
    for (int i = 0; i < 8; i++) res[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_spike_valid", 32'(a_spike_valid), 32'd0);
    check("rst_spike_out", 32'(a_spike_out), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_count", 32'(a_neuron_count), 32'd0);
    check("rst_overflow", 32'(a_overflow_err), 32'd0);
    rst_n = 1'b1;

    // 1: all zeros -> no spikes, latency 10
    send(10'd0);
    check("t1_busy", 32'(a_busy), 32'd1);
    wait_spike(lat);
    check("t1_latency", 32'(lat), 32'd10);
    check("t1_spike_out", 32'(a_spike_out), 32'h00);
    @(negedge clk);
    check("t1_count", 32'(a_neuron_count), 32'd1);
    check("t1_valid_drop", 32'(a_spike_valid), 32'd0);
    check("t1_idle", 32'(a_busy), 32'd0);

    // 2: all 100 -> fires every step
    send(10'd100);
    wait_spike(lat);
    check("t2_latency", 32'(lat), 32'd10);
    check("t2_spike_out", 32'(a_spike_out), 32'hFF);
    @(negedge clk);
    check("t2_count", 32'(a_neuron_count), 32'd2);

    // 3: all 40 -> 40,75(fire),40,75...
    send(10'd40);
    wait_spike(lat);
    check("t3_spike_out", 32'(a_spike_out), 32'hAA);
    @(negedge clk);
    check("t3_count", 32'(a_neuron_count), 32'd3);

    // 4: all 1023 -> saturates at t5 with THRESHOLD=4095
    send(10'd1023);
    wait_spike(lat);
    check("t4_sat_spike_out", 32'(b_spike_out), 32'h20);
    check("t4_sat_valid", 32'(b_spike_valid), 32'd1);
    check("t4_a_spike_out", 32'(a_spike_out), 32'hFF);
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("ready_without_valid", 32'(a_neuron_count), 32'd4);

    // 5: backpressure, pending bank, dropped set
    do_reset();
    spike_ready = 1'b0;
    send(10'd40);
    repeat (10) @(negedge clk);
    send(10'd100);
    repeat (10) @(negedge clk);
    send(10'd0);
    check("t5_overflow", 32'(a_overflow_err), 32'd1);
    check("t5_held_valid", 32'(a_spike_valid), 32'd1);
    check("t5_held_out", 32'(a_spike_out), 32'hAA);
    check("t5_count_held", 32'(a_neuron_count), 32'd0);
    check("t5_busy", 32'(a_busy), 32'd1);
    hs_exp[0] = 8'hAA;
    hs_exp[1] = 8'hFF;
    hs = 0;
    spike_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (a_spike_valid) begin
        if (hs < 2) check($sformatf("t5_hs%0d_out", hs), 32'(a_spike_out), 32'(hs_exp[hs]));
        hs++;
      end
      @(negedge clk);
    end
    check("t5_handshakes", 32'(hs), 32'd2);
    check("t5_count", 32'(a_neuron_count), 32'd2);
    check("t5_overflow_sticky", 32'(a_overflow_err), 32'd1);

    // 6: reset during INTEGRATE t=4
    do_reset();
    send(10'd40);
    repeat (5) @(negedge clk);
    check("t6_busy_before", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(a_spike_valid), 32'd0);
    check("t6_rst_out", 32'(a_spike_out), 32'd0);
    check("t6_rst_busy", 32'(a_busy), 32'd0);
    check("t6_rst_count", 32'(a_neuron_count), 32'd0);
    check("t6_rst_overflow", 32'(a_overflow_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(10'd40);
    wait_spike(lat);
    check("t6_latency", 32'(lat), 32'd10);
    check("t6_spike_out", 32'(a_spike_out), 32'hAA);
    @(negedge clk);
    check("t6_count", 32'(a_neuron_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
